// File: rtl/pkt_arb_pkg.sv
// Shared types for the packet push arbiter: FSM states, default field widths
// and the default-width packet record.
package pkt_arb_pkg;

  localparam int DEF_ID_W      = 32;
  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_PAYLOAD_W = 128;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_ID_W-1:0]      id;
    logic [DEF_ADDR_W-1:0]    src;
    logic [DEF_ADDR_W-1:0]    dest;
    logic [DEF_PAYLOAD_W-1:0] payload;
  } pkt_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid scanning upward
// from last_idx+1 with wrap; last_idx itself is considered last.
module rr_pick #(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/pkt_push_arbiter.sv
// Round-robin, burst-limited arbiter sharing the packet queue push port
// between NUM_REQ producers, with a registered push stage.
module pkt_push_arbiter
  import pkt_arb_pkg::*;
#(
  parameter int  NUM_REQ   = 4,
  parameter int  ID_W      = DEF_ID_W,
  parameter int  ADDR_W    = DEF_ADDR_W,
  parameter int  PAYLOAD_W = DEF_PAYLOAD_W,
  parameter int  MAX_BURST = 4,
  localparam int IDX_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*ID_W-1:0]        req_id,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_src,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_dest,
  input  logic [NUM_REQ*PAYLOAD_W-1:0]   req_payload,
  input  logic                           q_almost_full,
  output logic                           q_push,
  output logic [ID_W-1:0]                q_id,
  output logic [ADDR_W-1:0]              q_src,
  output logic [ADDR_W-1:0]              q_dest,
  output logic [PAYLOAD_W-1:0]           q_payload,
  output logic [IDX_W-1:0]               grant_idx,
  output logic                           busy,
  output logic [15:0]                    accept_count
);

  typedef struct packed {
    logic [ID_W-1:0]      id;
    logic [ADDR_W-1:0]    src;
    logic [ADDR_W-1:0]    dest;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_w_t;

  // Packed per-producer views; producer i sits at [i*W +: W].
  logic [NUM_REQ-1:0][ID_W-1:0]      id_lane;
  logic [NUM_REQ-1:0][ADDR_W-1:0]    src_lane;
  logic [NUM_REQ-1:0][ADDR_W-1:0]    dest_lane;
  logic [NUM_REQ-1:0][PAYLOAD_W-1:0] pay_lane;

  assign id_lane   = req_id;
  assign src_lane  = req_src;
  assign dest_lane = req_dest;
  assign pay_lane  = req_payload;

  state_t           state_q, state_d;
  pkt_w_t           pkt_q;
  logic [IDX_W-1:0] last_idx;
  logic [3:0]       bcnt;
  logic             can_push, gnt_valid, acc, burst_done, leave, regrant;
  logic [IDX_W-1:0] pick_from, pick_idx;
  logic             pick_found;

  // With the queue almost full, only one push may be in flight at a time.
  assign can_push   = !q_almost_full || !q_push;
  assign gnt_valid  = req_valid[grant_idx];
  assign acc        = busy && gnt_valid && can_push;
  assign burst_done = acc && ((bcnt + 4'd1) == 4'(MAX_BURST));
  assign leave      = busy && (burst_done || !gnt_valid);
  assign pick_from  = leave ? grant_idx : last_idx;
  assign regrant    = pick_found && (!busy || leave);

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid    (req_valid),
    .last_idx (pick_from),
    .found    (pick_found),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_found) state_d = GRANT;
      GRANT:   if (leave && !pick_found) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == GRANT);
    req_ready = '0;
    if (!rst && busy && can_push) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_idx <= '0;
      last_idx  <= IDX_W'(NUM_REQ - 1);
      bcnt      <= '0;
    end else begin
      if (leave) last_idx <= grant_idx;
      if (regrant) begin
        grant_idx <= pick_idx;
        bcnt      <= '0;
      end else if (acc) begin
        bcnt <= bcnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_push       <= 1'b0;
      pkt_q        <= '0;
      accept_count <= '0;
    end else begin
      q_push <= acc;
      if (acc) begin
        pkt_q.id      <= id_lane[grant_idx];
        pkt_q.src     <= src_lane[grant_idx];
        pkt_q.dest    <= dest_lane[grant_idx];
        pkt_q.payload <= pay_lane[grant_idx];
        accept_count  <= accept_count + 16'd1;
      end
    end
  end

  assign q_id      = pkt_q.id;
  assign q_src     = pkt_q.src;
  assign q_dest    = pkt_q.dest;
  assign q_payload = pkt_q.payload;

endmodule

// File: tb/tb_pkt_push_arbiter.sv
// Directed + randomized bench for pkt_push_arbiter against a grant-owner /
// burst-credit reference model.
module tb_pkt_push_arbiter;
  localparam int N = 4, ID_W = 32, AW = 8, PW = 128, MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*ID_W-1:0] req_id;
  logic [N*AW-1:0]   req_src, req_dest;
  logic [N*PW-1:0]   req_payload;
  logic              q_almost_full, q_push, busy;
  logic [ID_W-1:0]   q_id;
  logic [AW-1:0]     q_src, q_dest;
  logic [PW-1:0]     q_payload;
  logic [1:0]        grant_idx;
  logic [15:0]       accept_count;

  pkt_push_arbiter #(.NUM_REQ(N), .ID_W(ID_W), .ADDR_W(AW), .PAYLOAD_W(PW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_src(req_src), .req_dest(req_dest), .req_payload(req_payload),
    .q_almost_full(q_almost_full), .q_push(q_push), .q_id(q_id), .q_src(q_src),
    .q_dest(q_dest), .q_payload(q_payload), .grant_idx(grant_idx), .busy(busy),
    .accept_count(accept_count)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;
  logic [N-1:0] v;
  logic         af;
  logic [ID_W-1:0] pk_id [N];
  logic [AW-1:0]   pk_src [N], pk_dest [N];
  logic [PW-1:0]   pk_pay [N];
  int seq [N], acc_cnt [N];
  int push_ids [$], push_cyc [$];
  logic [N-1:0] obs_ready;

  // Reference model: who owns the port, how many accepts remain in the burst.
  bit m_active, m_qpush;
  int m_owner, m_last, m_credit;
  logic [ID_W-1:0] m_qid;
  logic [AW-1:0]   m_qsrc, m_qdest;
  logic [PW-1:0]   m_qpay;
  logic [15:0]     m_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_next(input int from, input logic [N-1:0] vv);
    for (int k = 1; k <= N; k++)
      if (vv[(from + k) % N]) return (from + k) % N;
    return -1;
  endfunction

  task automatic new_pkt(input int i);
    seq[i]++;
    pk_id[i]   = ID_W'(i * 1000 + seq[i]);
    pk_src[i]  = AW'(i);
    pk_dest[i] = AW'($urandom);
    pk_pay[i]  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic init_pkts();
    for (int i = 0; i < N; i++) begin
      seq[i] = -1;
      new_pkt(i);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_id[i*ID_W +: ID_W]    = pk_id[i];
      req_src[i*AW +: AW]       = pk_src[i];
      req_dest[i*AW +: AW]      = pk_dest[i];
      req_payload[i*PW +: PW]   = pk_pay[i];
    end
    req_valid     = v;
    q_almost_full = af;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive();
    #1 chk("rst_ready", 128'(req_ready), 128'(0));
    @(posedge clk);
    cyc++;
    m_active = 0; m_owner = 0; m_last = N - 1; m_credit = 0; m_qpush = 0;
    m_qid = '0; m_qsrc = '0; m_qdest = '0; m_qpay = '0; m_cnt = '0;
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_grant", 128'(grant_idx), 128'(0));
    chk("rst_push", 128'(q_push), 128'(0));
    chk("rst_qid", 128'(q_id), 128'(0));
    chk("rst_qsrc", 128'(q_src), 128'(0));
    chk("rst_qdest", 128'(q_dest), 128'(0));
    chk("rst_qpay", q_payload, 128'(0));
    chk("rst_cnt", 128'(accept_count), 128'(0));
    rst = 1'b0;
  endtask

  task automatic cycle();
    logic [N-1:0] er;
    bit can, acc, done;
    int g, p;
    drive();
    #1;
    g   = m_owner;
    can = !af || !m_qpush;
    er  = '0;
    if (m_active && can) er[g] = 1'b1;
    acc = m_active && v[g] && can;
    obs_ready = req_ready;
    chk("ready", 128'(req_ready), 128'(er));
    chk("busy", 128'(busy), 128'(m_active));
    chk("grant", 128'(grant_idx), 128'(g));
    @(posedge clk);
    cyc++;
    if (acc) begin
      m_qid = pk_id[g]; m_qsrc = pk_src[g]; m_qdest = pk_dest[g]; m_qpay = pk_pay[g];
      m_cnt = m_cnt + 16'd1;
      acc_cnt[g]++;
      m_credit--;
    end
    done = m_active && (!v[g] || (acc && m_credit == 0));
    if (!m_active) begin
      p = rr_next(m_last, v);
      if (p >= 0) begin m_active = 1; m_owner = p; m_credit = MB; end
    end else if (done) begin
      m_last = g;
      p = rr_next(m_last, v);
      if (p >= 0) begin m_owner = p; m_credit = MB; end
      else m_active = 0;
    end
    m_qpush = acc;
    if (acc) new_pkt(g);
    #1;
    chk("q_push", 128'(q_push), 128'(m_qpush));
    if (m_qpush) begin
      chk("q_id", 128'(q_id), 128'(m_qid));
      chk("q_src", 128'(q_src), 128'(m_qsrc));
      chk("q_dest", 128'(q_dest), 128'(m_qdest));
      chk("q_payload", q_payload, m_qpay);
    end
    chk("accept_count", 128'(accept_count), 128'(m_cnt));
    if (q_push) begin
      push_ids.push_back(int'(q_id));
      push_cyc.push_back(cyc);
    end
  endtask

  initial begin
    rst = 1'b1; v = '0; af = 1'b0;
    for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    init_pkts();
    do_reset();

    // Single producer, first grant latency and registered push.
    pk_id[0] = 32'd5;
    v = 4'b0001;
    cycle();
    chk("t1_idle_ready", 128'(obs_ready), 128'(0));
    cycle();
    chk("t1_ready0", 128'(obs_ready[0]), 128'(1));
    chk("t1_push", 128'(q_push), 128'(1));
    chk("t1_qid", 128'(q_id), 128'(5));
    chk("t1_cnt", 128'(accept_count), 128'(1));
    v = '0;
    cycle();

    // All four streaming: bursts of four in round-robin order, 16 back-to-back pushes.
    do_reset();
    init_pkts();
    v = 4'b1111;
    push_ids.delete(); push_cyc.delete();
    for (int c = 0; c < 17; c++) cycle();
    chk("t2_npush", 128'(push_ids.size()), 128'(16));
    for (int k = 0; k < 16; k++)
      chk("t2_order", 128'(k < push_ids.size() ? push_ids[k] : -1), 128'((k / 4) * 1000 + (k % 4)));

    // Producer 2 alone for 10 packets: 4,4,2 with seamless re-grants.
    v = 4'b0100;
    push_ids.delete(); push_cyc.delete();
    begin
      int base;
      base = acc_cnt[2];
      for (int g = 0; g < 60 && acc_cnt[2] - base < 10; g++) cycle();
      chk("t3_bound", 128'(acc_cnt[2] - base), 128'(10));
    end
    v = '0;
    cycle(); cycle();
    chk("t3_npush", 128'(push_ids.size()), 128'(10));
    if (push_ids.size() == 10) chk("t3_span", 128'(push_cyc[9] - push_cyc[0]), 128'(9));

    // Almost-full: accepts and pushes alternate, grant stays on producer 1.
    af = 1'b1;
    v  = 4'b0010;
    push_ids.delete(); push_cyc.delete();
    for (int c = 0; c < 9; c++) cycle();
    chk("t4_npush", 128'(push_ids.size()), 128'(4));
    for (int k = 0; k + 1 < push_cyc.size(); k++)
      chk("t4_gap", 128'(push_cyc[k+1] - push_cyc[k]), 128'(2));
    chk("t4_grant", 128'(grant_idx), 128'(1));

    // Reset in the middle of producer 3's burst, then 0 wins over 3.
    af = 1'b0;
    do_reset();
    init_pkts();
    v = 4'b1000;
    cycle(); cycle(); cycle();
    chk("t5_pre_push", 128'(q_push), 128'(1));
    v = 4'b1001;
    do_reset();
    cycle();
    chk("t5_busy", 128'(busy), 128'(1));
    chk("t5_first", 128'(grant_idx), 128'(0));
    cycle();

    // Randomized traffic and backpressure.
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        v[i] = v[i] ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) != 0);
      af = ($urandom_range(0, 9) < 3);
      cycle();
    end

    // accept_count wraps: 65537 accepts read back as 1.
    af = 1'b0;
    do_reset();
    init_pkts();
    v = 4'b1111;
    for (int c = 0; c < 65538; c++) cycle();
    chk("wrap_cnt", 128'(accept_count), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pkt_push_arbiter.md
# pkt_push_arbiter

Round-robin arbiter that shares the single push port of the packet queue (`scalable_data_structure`) between `NUM_REQ` packet producers. Each producer offers packets over a valid/ready handshake. The arbiter grants one producer at a time, allows bounded bursts, and forwards accepted packets to the queue through a registered push stage. Backpressure comes from the queue's almost-full indication, so the queue never overflows.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producer ports (2..8).
- `ID_W`, 32: packet id width.
- `ADDR_W`, 8: src/dest endpoint index width (numeric; replaces string src/dest).
- `PAYLOAD_W`, 128: payload width.
- `MAX_BURST`, 4: maximum consecutive accepts per grant (1..15).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  producer i offers a packet.
- `req_ready`  out  NUM_REQ  producer i packet accepted this cycle when valid&ready.
- `req_id`  in  NUM_REQ*ID_W  packed per producer, producer 0 in LSBs.
- `req_src`, `req_dest`  in  NUM_REQ*ADDR_W each  packed per producer.
- `req_payload`  in  NUM_REQ*PAYLOAD_W  packed per producer.
- `q_almost_full`  in  1  queue has ≤1 free entry.
- `q_push`  out  1  registered push strobe to queue.
- `q_id`, `q_src`, `q_dest`, `q_payload`  out  ID_W/ADDR_W/ADDR_W/PAYLOAD_W  registered packet fields.
- `grant_idx`  out  $clog2(NUM_REQ)  currently granted producer.
- `busy`  out  1  FSM in GRANT state.
- `accept_count`  out  16  total packets pushed, wraps mod 2^16.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: grant held by `grant_idx`, burst counter `bcnt`.
- IDLE → GRANT: any `req_valid`. Select the first valid producer scanning from `last_idx+1` upward with wrap. Set `bcnt=0`.
- Accept condition `acc = busy & req_valid[grant_idx] & (!q_almost_full | !q_push)`.
- `req_ready[i] = busy & (i==grant_idx) & (!q_almost_full | !q_push)`. All other bits are 0.
- On `acc`: capture the granted producer's fields into the `q_*` registers, set `q_push=1` next cycle, increment `bcnt` and `accept_count`.
- GRANT exits at the end of a cycle where either of these holds:
  - `acc` and `bcnt+1==MAX_BURST`;
  - `req_valid[grant_idx]==0`.
- On exit, set `last_idx=grant_idx`. If any other producer is valid, re-grant directly (GRANT→GRANT) using the round-robin scan from `last_idx+1`. Otherwise go to IDLE.
- If the current grantee is the only valid producer after its burst expires, it is re-granted with `bcnt=0`.
- Backpressure (accept blocked by `q_almost_full`): grant is held, `bcnt` is unchanged, no rotation. Backpressure never ends a burst.
- Fairness bound: a continuously valid producer is accepted within `(NUM_REQ-1)*MAX_BURST` accepts by others.
- Width rules:
  - `bcnt` is 4 bits.
  - `accept_count` wraps 0xFFFF→0x0000.
  - Field slicing: producer i occupies bits `[i*W +: W]`.

## Timing
- Reset values, effective the cycle after `rst` is sampled high:
  - FSM = IDLE, `busy=0`, `grant_idx=0`, `last_idx=NUM_REQ-1` (so producer 0 wins first).
  - `bcnt=0`, `q_push=0`, `q_id/q_src/q_dest/q_payload=0`, `accept_count=0`.
  - `req_ready` forced 0 while `rst` is high.
- Latency:
  - First valid request: grant registered in 1 cycle, so `req_ready` rises in the cycle after `req_valid` is first seen in IDLE.
  - Accept at edge t → `q_push`=1 with the fields during cycle t+1.
  - `q_push` is 1 for exactly one cycle per accept.
- Throughput is 1 packet/cycle while `q_almost_full=0`.
- With `q_almost_full=1`:
  - at most 1 push is outstanding;
  - accepts occur only in cycles where `q_push=0`, i.e. alternate cycles until the queue reports full.
- `q_almost_full` is combinational into `req_ready`. No other combinational input→output paths.
- Reset mid-burst: the in-flight `q_push` is dropped, the packet is lost by design, and all state returns to reset values.
- Simultaneous exit and new request: rotation uses the `req_valid` values of the exit cycle.

## Structure
- Package `pkt_arb_pkg`:
  - `pkt_t` struct (id, src, dest, payload);
  - FSM state enum `{IDLE, GRANT}`;
  - `ADDR_W`/`PAYLOAD_W` defaults.
- Sub-module `rr_pick`: combinational round-robin picker taking `valid[NUM_REQ]` and `last_idx`, returning `found` and `idx`. Reusable on the pop side.
- Top-level `pkt_push_arbiter`: instantiates one `rr_pick`, plus the FSM, burst counter and output registers.

## Test plan
- Reset, then `req_valid=4'b0001`, id=5 → `req_ready[0]` asserted one cycle later. `q_push` pulses with `q_id=5` the cycle after the accept. `accept_count=1`.
- All 4 producers continuously valid, MAX_BURST=4, `q_almost_full=0` → grant order 0,0,0,0,1,1,1,1,2,…,3, then back to 0. 16 consecutive `q_push` cycles. Ids arrive in that order.
- Producer 2 valid alone for 10 packets → bursts of 4,4,2 with a re-grant to 2 each time. No idle cycle between bursts. `q_push` every cycle.
- `q_almost_full=1` held with producer 1 streaming → accepts every other cycle and `q_push` alternates 1,0,1,0. `bcnt` advances only on accepts, and the grant stays on 1.
- `rst` asserted mid-burst (producer 3, bcnt=2) → next cycle `busy=0`, `q_push=0`, `accept_count=0`. Post-reset the first grant goes to producer 0 when 0 and 3 are both valid.
- 65537 accepts → `accept_count` reads 1. Integration with the queue: push 1000 packets from 4 producers with ids i*1000+k → popped ids preserve per-producer order and the queue never overflows.
